pla_seq_eval: RTL and testbench

- Sequential, parametrised evaluator for two-level PLA covers, generalising the fixed 16-input/1-output benchmark netlists to N_IN inputs, N_OUT outputs and up to DEPTH cubes.
- The cover is loaded at run time through an append-only config port, then evaluated one cube per cycle against handshaken input vectors.
- Used in the benchmark harness to check synthesised netlists against their PLA source on-chip.

---
 rtl/pla_seq_pkg.sv | 31 +++
 rtl/pla_cube_match.sv | 18 +
 rtl/pla_seq_eval.sv | 173 +++++++++++++++++
 tb/tb_pla_seq_eval.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pla_seq_pkg.sv
// Purpose: shared types for the sequential PLA cover evaluator.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
//
// The cube struct is sized at the widest cover the evaluator supports
// (PLA_MAX_IN inputs, PLA_MAX_OUT outputs). Narrower instances zero-pad:
// a zero care bit drops the literal and a zero out bit never sets acc,
// so the padding is inert.
package pla_seq_pkg;

    localparam int PLA_MAX_IN  = 64;
    localparam int PLA_MAX_OUT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [PLA_MAX_IN-1:0]  care;
        logic [PLA_MAX_IN-1:0]  val;
        logic [PLA_MAX_OUT-1:0] out;
    } cube_t;

    // Width that holds every value 0..depth (cube count, scan index, K).
    function automatic int idx_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pla_cube_match.sv
// Purpose: tests one PLA cube against an input vector.
// Latency: combinational.
// Backpressure: none.
//
// Ports: x (input vector), care (1 = literal present), val (literal
// polarity, 1 = positive), match (1 when every present literal is met).
module pla_cube_match #(
    parameter int W = 16
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] care,
    input  logic [W-1:0] val,
    output logic         match
);

    assign match = (((x ^ val) & care) == '0);

endmodule

// File: rtl/pla_seq_eval.sv
// Purpose: run-time loadable PLA cover evaluated one cube per cycle.
// Latency: K+1 cycles worst case from acceptance (K = cubes loaded), 1 when K = 0.
// Backpressure: in_ready low while scanning or holding a result; result held until out_ready.
//
// Ports: clk, rst_n (async active-low); cfg_we/cfg_clr/cfg_care/cfg_val/
// cfg_out append or clear the cover (IDLE only); cfg_full, cfg_drop status;
// in_valid/in_ready/in_x input vector; out_valid/out_ready/out_y result;
// busy high while scanning or holding a result.
// Optional: define PLA_ESOP_EN to add esop_mode (XOR accumulation, no early exit).
// Supports N_IN <= PLA_MAX_IN and N_OUT <= PLA_MAX_OUT.
module pla_seq_eval
    import pla_seq_pkg::*;
#(
    parameter int N_IN  = 16,
    parameter int N_OUT = 1,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic             cfg_clr,
    input  logic [N_IN-1:0]  cfg_care,
    input  logic [N_IN-1:0]  cfg_val,
    input  logic [N_OUT-1:0] cfg_out,
    output logic             cfg_full,
    output logic             cfg_drop,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_x,
`ifdef PLA_ESOP_EN
    input  logic             esop_mode,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out_y,
    output logic             busy
);

    localparam int IW = idx_width(DEPTH);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IW-1:0] DEPTH_C = IW'(DEPTH);
    // Valid output bits all set; padding bits stay zero in acc.
    localparam logic [PLA_MAX_OUT-1:0] ACC_ONES = ~({PLA_MAX_OUT{1'b1}} << N_OUT);

    state_t                 state, state_nxt;
    logic [IW-1:0]          count;
    logic [IW-1:0]          k_q;
    logic [IW-1:0]          idx;
    logic [N_IN-1:0]        x_q;
    logic [PLA_MAX_OUT-1:0] acc;
    logic [PLA_MAX_OUT-1:0] acc_upd;
    logic                   esop_q;
    logic                   cube_hit;
    logic                   cfg_drop_nxt;
    logic                   cube_wr;
    cube_t                  cube_mem [DEPTH];
    cube_t                  cube_rd;

    assign cfg_full = (count == DEPTH_C);

    // Only IDLE may touch the cover; clear beats append.
    assign cube_wr      = (state == IDLE) && cfg_we && !cfg_clr && !cfg_full;
    assign cfg_drop_nxt = ((state != IDLE) && (cfg_we || cfg_clr)) ||
                          ((state == IDLE) && cfg_we && !cfg_clr && cfg_full);

    // Cover storage carries no reset; entries at or above count are never read.
    always_ff @(posedge clk) begin
        if (cube_wr) begin
            cube_mem[count[AW-1:0]] <= '{care: PLA_MAX_IN'(cfg_care),
                                         val:  PLA_MAX_IN'(cfg_val),
                                         out:  PLA_MAX_OUT'(cfg_out)};
        end
    end

    // idx < K <= DEPTH whenever the read result is consumed.
    assign cube_rd = cube_mem[idx[AW-1:0]];

    pla_cube_match #(.W(PLA_MAX_IN)) u_match (
        .x     (PLA_MAX_IN'(x_q)),
        .care  (cube_rd.care),
        .val   (cube_rd.val),
        .match (cube_hit)
    );

    always_comb begin
        acc_upd = acc;
        if (cube_hit) begin
            acc_upd = esop_q ? (acc ^ cube_rd.out) : (acc | cube_rd.out);
        end
    end

`ifdef PLA_ESOP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            esop_q <= 1'b0;
        end else if ((state == IDLE) && in_valid) begin
            esop_q <= esop_mode;
        end
    end
`else
    assign esop_q = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_y     = '0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_nxt = (count == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                // Last cube processed, or SOP result already saturated.
                if ((idx == k_q - 1'b1) || (!esop_q && (acc_upd == ACC_ONES))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                out_y     = acc[N_OUT-1:0];
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            k_q      <= '0;
            idx      <= '0;
            x_q      <= '0;
            acc      <= '0;
            cfg_drop <= 1'b0;
        end else begin
            cfg_drop <= cfg_drop_nxt;
            if (state == IDLE) begin
                if (cfg_clr) begin
                    count <= '0;
                end else if (cube_wr) begin
                    count <= count + 1'b1;
                end
                // K is the count before any same-cycle append.
                if (in_valid) begin
                    x_q <= in_x;
                    k_q <= count;
                    idx <= '0;
                    acc <= '0;
                end
            end else if (state == SCAN) begin
                acc <= acc_upd;
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pla_seq_eval.sv
// Purpose: directed self-checking bench for pla_seq_eval (DEPTH = 4).
// Latency: cycles counted from the acceptance edge (cycle 0).
// Backpressure: exercises held results, blocked inputs and dropped config.
module tb_pla_seq_eval;

    localparam int N_IN  = 16;
    localparam int N_OUT = 1;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we, cfg_clr;
    logic [N_IN-1:0]  cfg_care, cfg_val;
    logic [N_OUT-1:0] cfg_out;
    logic             cfg_full, cfg_drop;
    logic             in_valid, in_ready;
    logic [N_IN-1:0]  in_x;
    logic             out_valid, out_ready;
    logic [N_OUT-1:0] out_y;
    logic             busy;
`ifdef PLA_ESOP_EN
    logic             esop_mode;
`endif

    int n_tests  = 0;
    int n_fail   = 0;
    int drop_cnt = 0;

    pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_clr   (cfg_clr),
        .cfg_care  (cfg_care),
        .cfg_val   (cfg_val),
        .cfg_out   (cfg_out),
        .cfg_full  (cfg_full),
        .cfg_drop  (cfg_drop),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
`ifdef PLA_ESOP_EN
        .esop_mode (esop_mode),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Each cycle of cfg_drop high counts as one pulse.
    always @(posedge clk) if (cfg_drop) drop_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic load(input logic [15:0] care, input logic [15:0] val, input logic [0:0] o);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_care = care;
        cfg_val  = val;
        cfg_out  = o;
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    // Sends one vector, optionally injecting a cfg write in cycle 1 and
    // optionally holding out_ready low for 5 cycles with in_valid asserted.
    task automatic send(input string tag, input logic [15:0] x, input bit esop,
                        input bit inject, input bit hold,
                        input logic [0:0] exp_y, input int exp_lat);
        int cyc;
        @(negedge clk);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_x     = x;
`ifdef PLA_ESOP_EN
        esop_mode = esop;
`else
        if (esop) $display("note: esop request ignored in SOP-only build");
`endif
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 1;
        if (inject) begin
            cfg_we   = 1'b1;
            cfg_care = '0;
            cfg_val  = '0;
            cfg_out  = 1'b1;
        end
        while (!out_valid && cyc < 64) begin
            @(negedge clk);
            cfg_we = 1'b0;
            cyc++;
        end
        cfg_we = 1'b0;
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
        chk({tag, ".out_y"}, 32'(out_y), 32'(exp_y));
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                in_valid = 1'b1;
                in_x     = 16'h0401;
                @(negedge clk);
                chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
                chk({tag, ".hold_y"}, 32'(out_y), 32'(exp_y));
                chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".back_idle"}, {30'd0, out_valid, busy}, 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_clr   = 1'b0;
        cfg_care  = '0;
        cfg_val   = '0;
        cfg_out   = '0;
        in_valid  = 1'b0;
        in_x      = '0;
        out_ready = 1'b0;
`ifdef PLA_ESOP_EN
        esop_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_y", 32'(out_y), 32'd0);
        chk("rst.cfg_full", 32'(cfg_full), 32'd0);
        chk("rst.cfg_drop", 32'(cfg_drop), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);

        // Empty cover: result 0 in cycle 1.
        send("k0", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("k0.no_drop", 32'(drop_cnt), 32'd0);

        load(16'h0003, 16'h0001, 1'b1);
        load(16'h0400, 16'h0400, 1'b1);
        load(16'hFFFF, 16'hFFFF, 1'b1);

        // Cube 0 hits; output saturates, so the scan stops after it.
        send("early", 16'h0401, 1'b0, 1'b0, 1'b0, 1'b1, 2);
        // No cube hits: full scan of 3 cubes, with a write attempted mid-scan.
        send("miss_inject", 16'h0002, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        chk("scan_drop.cnt", 32'(drop_cnt), 32'd1);
        // An always-true cube would have landed at index 3 had the write gone in.
        send("count_kept", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        chk("count_kept.full", 32'(cfg_full), 32'd0);

        load(16'h8000, 16'h0000, 1'b1);
        chk("fourth.full", 32'(cfg_full), 32'd1);
        load(16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        chk("full_drop.cnt", 32'(drop_cnt), 32'd2);
        chk("full_drop.full", 32'(cfg_full), 32'd1);

        // Only cube 3 (bit 15 = 0) hits: result after all 4 cubes, then held.
        send("hold", 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 5);
        send("after_hold", 16'h0401, 1'b0, 1'b0, 1'b0, 1'b1, 2);

        // Asynchronous reset in the middle of a 4-cube scan.
        @(negedge clk);
        in_valid = 1'b1;
        in_x     = 16'h0002;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst.busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.cfg_full", 32'(cfg_full), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send("post_rst", 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        chk("drop_total", 32'(drop_cnt), 32'd2);

        // Clear wins over a simultaneous append.
        load(16'h0000, 16'h0000, 1'b1);
        @(negedge clk);
        cfg_we  = 1'b1;
        cfg_clr = 1'b1;
        @(negedge clk);
        cfg_we  = 1'b0;
        cfg_clr = 1'b0;
        send("clr_wins", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);

`ifdef PLA_ESOP_EN
        load(16'h0001, 16'h0001, 1'b1);
        load(16'h0001, 16'h0001, 1'b1);
        send("esop_xor", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        send("esop_off", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
